linea_serializer: RTL and testbench

//   Upstream feeder for the serial-line recognizer FSM. Accepts parallel words over
//   a valid/ready handshake and buffers them in a 2-entry queue.

---
 rtl/linea_serializer.sv | 174 +++++++++++++++++
 tb/tb_linea_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/linea_serializer.sv
`default_nettype none
// ============================================================================
// Module   : linea_serializer
// Brief    : 2-entry queued parallel-to-serial feeder for the LINEA line,
//            MSB-first, with a programmable idle gap between words.
// Revision : 1.0 - initial release
// ============================================================================
module linea_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   LW         = 4,
    parameter int   GAP        = 1,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    output logic             linea,
    output logic             linea_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);
    localparam int                 c_gap_w    = (GAP < 1) ? 1 : $clog2(GAP + 1);
    localparam bit                 c_has_gap  = (GAP > 0);
    localparam logic [c_gap_w-1:0] c_gap_init = c_gap_w'(GAP);
    localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);
    localparam logic [LW-1:0]      c_full_len = LW'(WIDTH);
    localparam logic [LW-1:0]      c_len_one  = LW'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_d;
    logic [WIDTH-1:0]   r_q_data [2];
    logic [LW-1:0]      r_q_len  [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic [WIDTH-1:0]   r_shreg;
    logic [LW-1:0]      r_bitcnt;
    logic [c_gap_w-1:0] r_gapcnt;
    logic               r_linea;
    logic               r_linea_valid;
    logic [CNT_W-1:0]   r_words_sent;
    logic               w_push;
    logic               w_load;
    logic               w_last_bit;
    logic               w_q_nonempty;
    logic               w_linea_d;
    logic               w_linea_valid_d;
    logic [LW-1:0]      w_push_len;

    assign in_ready     = (r_count != 2'd2) && !reset;
    assign w_push       = in_valid && in_ready;
    assign w_q_nonempty = (r_count != 2'd0);
    // Lengths are normalised on entry so the shifter only ever sees 1..WIDTH.
    assign w_push_len   = (in_len == '0 || in_len > c_full_len) ? c_full_len : in_len;

    assign linea       = r_linea;
    assign linea_valid = r_linea_valid;
    assign busy        = (r_state != c_st_idle) || w_q_nonempty;
    assign words_sent  = r_words_sent;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_load) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= in_data;
            r_q_len[r_wr_ptr]  <= w_push_len;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d  = r_state;
        w_load     = 1'b0;
        w_last_bit = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_q_nonempty) begin
                    w_load    = 1'b1;
                    w_state_d = c_st_shift;
                end
            end
            c_st_shift: begin
                if (r_bitcnt <= c_len_one) begin
                    w_last_bit = 1'b1;
                    if (c_has_gap) begin
                        w_state_d = c_st_gap;
                    end else if (w_q_nonempty) begin
                        w_load    = 1'b1;
                        w_state_d = c_st_shift;
                    end else begin
                        w_state_d = c_st_idle;
                    end
                end
            end
            c_st_gap: begin
                if (r_gapcnt <= c_gap_one) begin
                    if (w_q_nonempty) begin
                        w_load    = 1'b1;
                        w_state_d = c_st_shift;
                    end else begin
                        w_state_d = c_st_idle;
                    end
                end
            end
            default: w_state_d = c_st_idle;
        endcase
    end

    always_comb begin
        w_linea_d       = IDLE_LEVEL;
        w_linea_valid_d = 1'b0;
        if (r_state == c_st_shift) begin
            w_linea_d       = r_shreg[WIDTH-1];
            w_linea_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_linea       <= IDLE_LEVEL;
            r_linea_valid <= 1'b0;
            r_shreg       <= '0;
            r_bitcnt      <= '0;
            r_gapcnt      <= '0;
            r_words_sent  <= '0;
        end else begin
            r_linea       <= w_linea_d;
            r_linea_valid <= w_linea_valid_d;
            // A load on the last bit overrides the shift so words run back-to-back.
            if (w_load) begin
                r_shreg  <= r_q_data[r_rd_ptr];
                r_bitcnt <= r_q_len[r_rd_ptr];
            end else if (r_state == c_st_shift) begin
                r_shreg  <= r_shreg << 1;
                r_bitcnt <= r_bitcnt - c_len_one;
            end
            if (w_last_bit && c_has_gap) begin
                r_gapcnt <= c_gap_init;
            end else if (r_state == c_st_gap) begin
                r_gapcnt <= r_gapcnt - c_gap_one;
            end
            if (w_last_bit && (r_words_sent != '1)) begin
                r_words_sent <= r_words_sent + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_linea_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_linea_serializer
// Brief    : Scoreboard bench for linea_serializer; one GAP=1 and one GAP=0
//            (2-bit counter) instance share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linea_serializer;
    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       v0, v1;
    logic [7:0] d0, d1;
    logic [3:0] l0, l1;
    logic       r0, r1, lin0, lin1, lv0, lv1, b0, b1;
    logic [1:0] ws0;
    logic [15:0] ws1;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   exp_words[2];
    int   sat_lim[2];
    bit   prev_last1;
    int   checks;
    int   errors;
    int   waited;
    int   run;

    linea_serializer #(.WIDTH(8), .LW(4), .GAP(1), .IDLE_LEVEL(1'b0), .CNT_W(16)) dut1 (
        .clock(clk), .reset(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_len(l1),
        .linea(lin1), .linea_valid(lv1), .busy(b1), .words_sent(ws1)
    );

    linea_serializer #(.WIDTH(8), .LW(4), .GAP(0), .IDLE_LEVEL(1'b0), .CNT_W(2)) dut0 (
        .clock(clk), .reset(rst), .in_valid(v0), .in_ready(r0), .in_data(d0), .in_len(l0),
        .linea(lin0), .linea_valid(lv0), .busy(b0), .words_sent(ws0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: one call per DUT per falling edge.
    task automatic mon(input int id, input logic lv, input logic vl, input int ws);
        exp_t e;
        bit   have;
        e    = '0;
        have = 1'b0;
        if (id == 1 && prev_last1) begin
            checks++;
            if (vl) begin
                errors++;
                $display("FAIL gap_dut1: got linea_valid=1 right after a word, expected idle cycle");
            end
        end
        if (vl) begin
            if (id == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            if (id == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL unexpected_bit dut%0d: got linea_valid=1, expected no bit", id);
            end else begin
                if (lv !== e.b) begin
                    errors++;
                    $display("FAIL bit dut%0d: got linea=%b, expected %b", id, lv, e.b);
                end
                if (e.last) begin
                    if (exp_words[id] < sat_lim[id]) exp_words[id]++;
                    chk($sformatf("words_sent_dut%0d", id), ws, exp_words[id]);
                end
            end
        end else begin
            chk($sformatf("idle_level_dut%0d", id), int'(lv), 0);
        end
        if (id == 1) prev_last1 = vl && have && e.last;
    endtask

    always @(negedge clk) begin
        mon(1, lin1, lv1, int'(ws1));
        mon(0, lin0, lv0, int'(ws0));
    end

    // pat holds the hand-computed bit sequence right-aligned, first bit at pat[n-1].
    task automatic push_word(input int id, input logic [7:0] d, input logic [3:0] l,
                             input logic [7:0] pat, input int n, output int stall);
        logic acc;
        bit   done;
        exp_t e;
        stall = 0;
        done  = 1'b0;
        if (id == 0) begin v0 = 1'b1; d0 = d; l0 = l; end
        else         begin v1 = 1'b1; d1 = d; l1 = l; end
        for (int c = 0; c < 100 && !done; c++) begin
            acc = (id == 0) ? r0 : r1;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
            else     stall++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout dut%0d: word %h not accepted, expected accept within 100 cycles", id, d);
        end else begin
            for (int i = 0; i < n; i++) begin
                e.b    = pat[n-1-i];
                e.last = (i == n - 1);
                if (id == 0) exp_q0.push_back(e);
                else         exp_q1.push_back(e);
            end
        end
    endtask

    task automatic drain(input int id);
        bit done;
        done = 1'b0;
        if (id == 0) v0 = 1'b0;
        else         v1 = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (id == 0) done = !b0 && !lv0;
            else         done = !b1 && !lv1;
        end
        chk($sformatf("drain_done_dut%0d", id), int'(done), 1);
        @(posedge clk);
        #1;
        chk($sformatf("expected_bits_left_dut%0d", id),
            (id == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_words[0] = 0; exp_words[1] = 0;
        sat_lim[0] = 3; sat_lim[1] = 65535;
        prev_last1 = 1'b0;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; l0 = '0; l1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        chk("reset_linea", int'(lin1), 0);
        chk("reset_linea_valid", int'(lv1), 0);
        chk("reset_in_ready", int'(r1), 1);
        chk("reset_busy", int'(b1), 0);
        chk("reset_words_sent", int'(ws1), 0);
        chk("reset_in_ready_dut0", int'(r0), 1);
        @(posedge clk);
        #1;

        // A5 with len=0 means the full 8 bits
        push_word(1, 8'hA5, 4'd0, 8'b1010_0101, 8, waited);
        drain(1);
        chk("words_after_a5", int'(ws1), 1);

        // Short word, full word, then a third word fills the queue
        push_word(1, 8'hF0, 4'd3, 8'b0000_0111, 3, waited);
        push_word(1, 8'h0F, 4'd8, 8'b0000_1111, 8, waited);
        chk("ready_one_entry", int'(r1), 1);
        push_word(1, 8'hC3, 4'd4, 8'b0000_1100, 4, waited);
        chk("ready_two_entries", int'(r1), 0);

        // Held in_valid against a full queue must stall, not duplicate
        push_word(1, 8'h5A, 4'd8, 8'b0101_1010, 8, waited);
        chk("stall_seen", int'(waited > 0), 1);
        drain(1);
        chk("words_after_burst", int'(ws1), 5);

        // len=1 and len>WIDTH
        push_word(1, 8'h7F, 4'd1, 8'b0000_0000, 1, waited);
        push_word(1, 8'h96, 4'd9, 8'b1001_0110, 8, waited);
        drain(1);
        chk("words_after_edge_lens", int'(ws1), 7);

        // GAP=0: three words must stream as 24 contiguous valid bits
        push_word(0, 8'h81, 4'd8,  8'b1000_0001, 8, waited);
        push_word(0, 8'h7E, 4'd0,  8'b0111_1110, 8, waited);
        push_word(0, 8'hFF, 4'd12, 8'b1111_1111, 8, waited);
        v0 = 1'b0;
        for (int c = 0; c < 20 && !lv0; c++) begin
            @(posedge clk);
            #1;
        end
        run = 0;
        while (lv0 && run < 40) begin
            run++;
            @(posedge clk);
            #1;
        end
        chk("gap0_contiguous_bits", run, 24);
        drain(0);
        chk("words_dut0", int'(ws0), 3);
        push_word(0, 8'hAA, 4'd2, 8'b0000_0010, 2, waited);
        drain(0);
        chk("words_dut0_saturated", int'(ws0), 3);

        // Reset during bit 4 of a word with another word queued
        push_word(1, 8'hB4, 4'd0, 8'b1011_0100, 8, waited);
        push_word(1, 8'h3C, 4'd0, 8'b0011_1100, 8, waited);
        v1 = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("ready_in_reset", int'(r1), 0);
        @(posedge clk);
        #1;
        chk("abort_linea", int'(lin1), 0);
        chk("abort_linea_valid", int'(lv1), 0);
        chk("abort_words_sent", int'(ws1), 0);
        chk("abort_busy", int'(b1), 0);
        exp_q0.delete();
        exp_q1.delete();
        exp_words[0] = 0;
        exp_words[1] = 0;
        prev_last1 = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(r1), 1);
        repeat (12) @(posedge clk);
        #1;
        chk("busy_after_abort", int'(b1), 0);
        push_word(1, 8'h01, 4'd2, 8'b0000_0000, 2, waited);
        drain(1);
        chk("words_after_recovery", int'(ws1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
